// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the modify_uart_rx UART receiver.
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    function automatic int bit_cycles(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx_pin synchronizer, falling-edge detect and sample voter.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote over the last three synced values.
module uart_rx_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic rx_pin,
    output logic rx_s,
    output logic fall,
    output logic vote
);
    import uart_rx_pkg::*;

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = rx_pin;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Reset to the idle (high) level so a line held low at release reads as an edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rx_s = s2_q;
    assign fall = s3_q & ~s2_q;

`ifdef UART_RX_MAJORITY_EN
    logic s4_q, s4_d;

    always_comb s4_d = s3_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) s4_q <= 1'b1;
        else          s4_q <= s4_d;
    end

    assign vote = (s2_q & s3_q) | (s2_q & s4_q) | (s3_q & s4_q);
`else
    assign vote = s2_q;
`endif

endmodule

// File: rtl/modify_uart_rx.sv
// UART receiver: start bit, Challenge_Bit data bits LSB-first, one stop bit.
// Optional UART_RX_MAJORITY_EN moves each decision one clock later and votes 2-of-3.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synced line
// START | timing to mid start bit, rejecting glitches
// DATA  | sampling data bits at mid-bit, LSB first
// STOP  | checking the stop bit, publishing the word if high
module modify_uart_rx #(
    parameter int Challenge_Bit = 8,
    parameter int CLK_FRE       = 16,
    parameter int BAUD_RATE     = 115200
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     rx_pin,
    output logic [Challenge_Bit-1:0] rx_data,
    output logic                     rx_data_valid
);
    import uart_rx_pkg::*;

    localparam int BIT_CYC  = bit_cycles(CLK_FRE, BAUD_RATE);
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);
    localparam int IDX_W    = $clog2(Challenge_Bit + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif
    // Decisions land OFS cycles late; rearming the counter at OFS keeps bit timing unchanged
    localparam logic [CNT_W-1:0] START_HIT = CNT_W'(HALF_CYC - 1 + OFS);
    localparam logic [CNT_W-1:0] BIT_HIT   = CNT_W'(BIT_CYC - 1 + OFS);
    localparam logic [CNT_W-1:0] CNT_REARM = CNT_W'(OFS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(Challenge_Bit - 1);

    logic rx_s, fall, vote;

    uart_rx_sync u_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .rx_pin  (rx_pin),
        .rx_s    (rx_s),
        .fall    (fall),
        .vote    (vote)
    );

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [Challenge_Bit-1:0] shift_q, shift_d;
    logic [Challenge_Bit-1:0] data_q, data_d;
    logic                     valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == START_HIT) begin
                    if (!vote) begin
                        state_d = DATA;
                        idx_d   = '0;
                        cnt_d   = CNT_REARM;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_HIT) begin
                    // LSB-first: after the last shift, bit 0 sits in shift_q[0]
                    shift_d = {vote, shift_q[Challenge_Bit-1:1]};
                    cnt_d   = CNT_REARM;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == BIT_HIT) begin
                    if (vote) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;

endmodule

// File: tb/tb_modify_uart_rx.sv
// Directed and randomized frame tests for modify_uart_rx against a line-level model.
module tb_modify_uart_rx;

    localparam int BIT  = (16 * 1_000_000) / 115200;
    localparam int HALF_SQ = 960;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    logic [7:0] exp_data;

    modify_uart_rx dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .rx_pin        (rx_pin),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid)
    );

    always #31 clk = ~clk;

    always @(negedge clk) if (rx_data_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int cycles);
        rx_pin = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        hold(1'b0, BIT);
        for (int k = 0; k < nbits; k++) hold(b[k], BIT);
    endtask

    // Model: a correctly framed word replaces the held value with exactly one pulse
    task automatic frame_check(input string tag, input logic [7:0] b, input logic stop_ok, input int gap);
        int p0;
        p0 = pulses;
        send_bits(b, 8);
        hold(stop_ok, BIT);
        hold(1'b1, gap);
        if (stop_ok) exp_data = b;
        check({tag, "_pulses"}, pulses - p0, stop_ok ? 1 : 0);
        check({tag, "_data"}, rx_data, exp_data);
    endtask

    // Line level at each mid-bit point of a square wave whose first low half starts the frame
    function automatic logic [7:0] square_model(input int half);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            int t;
            t = (3 * BIT) / 2 + k * BIT;
            b[k] = ((t / half) % 2) == 1;
        end
        return b;
    endfunction

    initial begin
        int p0;
        n_reset  = 1'b0;
        rx_pin   = 1'b1;
        exp_data = 8'h00;

        repeat (40) begin
            @(negedge clk);
            rx_pin = 1'($urandom_range(0, 1));
            check("reset_data", rx_data, 8'h00);
            check("reset_valid", rx_data_valid, 1'b0);
        end
        rx_pin = 1'b1;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_pulses", pulses, 0);

        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, HALF_SQ);
            hold(1'b1, HALF_SQ);
        end
        exp_data = square_model(HALF_SQ);
        check("square_pulses", pulses - p0, 3);
        check("square_data", rx_data, exp_data);
        check("square_const", exp_data, 8'hC0);

        frame_check("a5", 8'hA5, 1'b1, 2 * BIT);

        p0 = pulses;
        hold(1'b0, 32);
        hold(1'b1, 3 * BIT);
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_data", rx_data, exp_data);

        frame_check("stop_err_3c", 8'h3C, 1'b0, 2 * BIT);
        frame_check("after_err_81", 8'h81, 1'b1, 2 * BIT);

        p0 = pulses;
        send_bits(8'h0F, 4);
        n_reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset_data", rx_data, 8'h00);
        check("midreset_valid", rx_data_valid, 1'b0);
        rx_pin = 1'b1;
        @(negedge clk);
        n_reset  = 1'b1;
        exp_data = 8'h00;
        hold(1'b1, 2 * BIT);
        check("midreset_pulses", pulses - p0, 0);
        check("midreset_hold", rx_data, exp_data);
        frame_check("after_rst_55", 8'h55, 1'b1, 2 * BIT);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            logic       ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            frame_check("random", b, ok, int'($urandom_range(5, 300)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
